// File: rtl/leaf_fifo_pkg.sv
// Shared constants, payload type and saturating-counter helper for the leaf stream FIFO.
package leaf_fifo_pkg;

  localparam int LEAF_DATA_W_DEF = 8;
  localparam int LEAF_DEPTH_DEF  = 4;
  localparam int STATS_W         = 16;

  typedef logic [LEAF_DATA_W_DEF-1:0] leaf_word_t;

  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    logic [STATS_W-1:0] r;
    if (v == {STATS_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(STATS_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/leaf_fifo_ptr.sv
// Wrap-around FIFO pointer: advances on adv, returns to zero on clr (clr wins).
module leaf_fifo_ptr
  import leaf_fifo_pkg::*;
#(
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          adv,
  output logic [AW-1:0] ptr
);

  logic [AW-1:0] ptr_r;
  logic [AW-1:0] ptr_nxt_s;

  // Next pointer value; natural binary wrap at 2**AW.
  always_comb begin
    ptr_nxt_s = ptr_r;
    if (clr) begin
      ptr_nxt_s = {AW{1'b0}};
    end else if (adv) begin
      ptr_nxt_s = ptr_r + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= {AW{1'b0}};
    end else begin
      ptr_r <= ptr_nxt_s;
    end
  end

  assign ptr = ptr_r;

endmodule

// File: rtl/leaf_stream_fifo.sv
// Leaf valid/ready byte-stream FIFO. Optional push counter enabled by LEAF_FIFO_STATS_EN.
module leaf_stream_fifo
  import leaf_fifo_pkg::*;
#(
  parameter int DATA_W = LEAF_DATA_W_DEF,
  parameter int DEPTH  = LEAF_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [$clog2(DEPTH):0] level
`ifdef LEAF_FIFO_STATS_EN
  ,
  output logic [STATS_W-1:0]     push_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] ONE_LVL  = {{(LW-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [LW-1:0]     level_r;
  logic [LW-1:0]     level_nxt_s;
  logic [AW-1:0]     wr_ptr_s;
  logic [AW-1:0]     rd_ptr_s;
  logic              push_s;
  logic              pop_s;

  // Ready depends only on registered occupancy and flush, never on out_ready.
  assign in_ready  = (level_r != FULL_LVL) && !flush;
  assign out_valid = (level_r != {LW{1'b0}});
  assign out_data  = mem_r[rd_ptr_s];
  assign level     = level_r;
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready && !flush;

  leaf_fifo_ptr #(.AW(AW)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .adv   (push_s),
    .ptr   (wr_ptr_s)
  );

  leaf_fifo_ptr #(.AW(AW)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .adv   (pop_s),
    .ptr   (rd_ptr_s)
  );

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_s] <= in_data;
    end
  end

  // Next occupancy from push/pop, flush overriding both.
  always_comb begin
    level_nxt_s = level_r;
    if (flush) begin
      level_nxt_s = {LW{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   level_nxt_s = level_r + ONE_LVL;
        2'b01:   level_nxt_s = level_r - ONE_LVL;
        default: level_nxt_s = level_r;
      endcase
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_r <= {LW{1'b0}};
    end else begin
      level_r <= level_nxt_s;
    end
  end

`ifdef LEAF_FIFO_STATS_EN
  logic [STATS_W-1:0] push_cnt_r;

  // Saturating accepted-push counter; survives flush, cleared only by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_cnt_r <= {STATS_W{1'b0}};
    end else if (push_s) begin
      push_cnt_r <= sat_inc(push_cnt_r);
    end
  end

  assign push_cnt = push_cnt_r;
`endif

endmodule

// File: tb/tb_leaf_stream_fifo.sv
// Scoreboard bench for leaf_stream_fifo: directed stimulus queues expected words, a negedge monitor checks pops.
module tb_leaf_stream_fifo;
  import leaf_fifo_pkg::*;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  leaf_word_t    in_data = 8'h00;
  logic          out_valid;
  logic          out_ready = 1'b0;
  leaf_word_t    out_data;
  logic [LW-1:0] level;
`ifdef LEAF_FIFO_STATS_EN
  logic [STATS_W-1:0] push_cnt;
  int unsigned        pc_model = 0;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  leaf_word_t exp_q[$];

  leaf_stream_fifo #(.DATA_W(8), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level)
`ifdef LEAF_FIFO_STATS_EN
    ,
    .push_cnt  (push_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a word that the bench knows will be accepted at the next edge; queue it as expected.
  task automatic push_word(input leaf_word_t d);
    in_valid = 1'b1;
    in_data  = d;
    exp_q.push_back(d);
    tick();
`ifdef LEAF_FIFO_STATS_EN
    if (pc_model < 65535) pc_model++;
`endif
    in_valid = 1'b0;
  endtask

  // Monitor: compare every popped word against the scoreboard and bound the occupancy.
  always @(negedge clk) begin
    if (rst_n) begin
      if (level > LW'(DEPTH)) begin
        check("level_bound", 32'(level), 32'(DEPTH));
      end
      if (out_valid && out_ready && !flush) begin
        if (exp_q.size() == 0) begin
          check("pop_unexpected", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          check("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time 0x%0h expected finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset and idle
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_level", 32'(level), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef LEAF_FIFO_STATS_EN
    check("rst_push_cnt", 32'(push_cnt), 32'd0);
`endif
    tick();

    // Fill, hold fifth word, then drain
    out_ready = 1'b0;
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    push_word(8'h44);
    in_valid = 1'b1;
    in_data  = 8'h55;
    exp_q.push_back(8'h55);
    @(negedge clk);
    check("full_level", 32'(level), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    tick();
    tick();
    @(negedge clk);
    check("held_level", 32'(level), 32'd4);
    tick();
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    check("after_pop1_level", 32'(level), 32'd3);
    check("after_pop1_in_ready", 32'(in_ready), 32'd1);
    tick();
`ifdef LEAF_FIFO_STATS_EN
    pc_model++;
`endif
    in_valid = 1'b0;
    @(negedge clk);
    check("w55_accept_level", 32'(level), 32'd3);
    repeat (3) tick();
    @(negedge clk);
    check("drain_level", 32'(level), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);
    check("drain_q_empty", 32'(exp_q.size()), 32'd0);
    out_ready = 1'b0;
    tick();

    // Streaming: 20 words across pointer wrap, no bubbles
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      exp_q.push_back(8'(i));
      @(negedge clk);
      check("stream_in_ready", 32'(in_ready), 32'd1);
      if (i > 0) begin
        check("stream_level", 32'(level), 32'd1);
        check("stream_out_valid", 32'(out_valid), 32'd1);
      end
      tick();
`ifdef LEAF_FIFO_STATS_EN
      pc_model++;
`endif
    end
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    check("stream_end_level", 32'(level), 32'd0);
    check("stream_q_empty", 32'(exp_q.size()), 32'd0);
    out_ready = 1'b0;
    tick();

    // Flush with a simultaneous push
    push_word(8'hAA);
    push_word(8'hBB);
    @(negedge clk);
    check("pre_flush_level", 32'(level), 32'd2);
    tick();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hCC;
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("flush_level", 32'(level), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
`ifdef LEAF_FIFO_STATS_EN
    check("flush_push_cnt", 32'(push_cnt), 32'(pc_model));
`endif
    tick();
    push_word(8'h3C);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    check("post_flush_q_empty", 32'(exp_q.size()), 32'd0);
    tick();

    // Asynchronous reset mid-transfer
    push_word(8'h01);
    push_word(8'h02);
    push_word(8'h03);
    @(negedge clk);
    check("pre_rst_level", 32'(level), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_level", 32'(level), 32'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
`ifdef LEAF_FIFO_STATS_EN
    pc_model = 0;
    check("rst2_push_cnt", 32'(push_cnt), 32'd0);
`endif
    push_word(8'hA5);
    @(negedge clk);
    check("a5_out_data", 32'(out_data), 32'hA5);
    check("a5_level", 32'(level), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    check("a5_q_empty", 32'(exp_q.size()), 32'd0);
    tick();

`ifdef LEAF_FIFO_STATS_EN
    // Saturation of the push counter
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      in_data = 8'(i);
      exp_q.push_back(8'(i));
      tick();
      if (pc_model < 65535) pc_model++;
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    check("sat_push_cnt", 32'(push_cnt), 32'h0000_FFFF);
    check("sat_model", 32'(push_cnt), 32'(pc_model));
    check("sat_q_empty", 32'(exp_q.size()), 32'd0);
`endif

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/leaf_stream_fifo.md
# leaf_stream_fifo

Leaf buffering stage at the bottom of the generated `rootModule500` instance tree. It consumes a valid/ready byte stream from its parent node, holds up to DEPTH words in order, and presents them to the downstream consumer. It decouples producer and consumer timing so that hierarchy-elaboration tests exercise real sequential logic at every leaf.

## Interface
- DATA_W, 8, payload width in bits (≥1)
- DEPTH, 4, entry count; power of two, ≥2
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  reset, asynchronous assert, active-low; release is synchronous to clk
- flush  input  1  synchronous clear of all entries
- in_valid  input  1  producer has a word
- in_ready  output  1  block can accept a word
- in_data  input  DATA_W  producer payload
- out_valid  output  1  head word available
- out_ready  input  1  consumer takes the head word
- out_data  output  DATA_W  head payload
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- push_cnt  output  16  accepted-word counter (only with LEAF_FIFO_STATS_EN)

## Operation
- Push when in_valid && in_ready at a clock edge. Pop when out_valid && out_ready.
- in_ready = (level != DEPTH) && !flush. It is derived from registered state and flush only, with no path from out_ready. A full FIFO does not accept a push in the same cycle as a pop.
- out_valid = (level != 0). out_data = mem[rd_ptr], combinational from the storage array.
- Write and read pointers are $clog2(DEPTH) bits and wrap DEPTH-1 → 0 naturally.
- Occupancy update per cycle:
  - push only: level+1
  - pop only: level−1
  - push and pop together: unchanged; both pointers advance
- flush = 1:
  - Pointers and level go to 0; any push or pop in that cycle is discarded.
  - push_cnt is not cleared.
- There is no state machine beyond the occupancy counter. Overflow and underflow are impossible by construction. The bench asserts level ≤ DEPTH.
- Reset values: level=0, out_valid=0, in_ready=1 (after release), rd_ptr=wr_ptr=0, push_cnt=0. Storage contents are not reset; out_data is don't-care while out_valid=0.
- Reset asserted mid-transfer drops all contents immediately (asynchronously). Outputs take reset values in the same cycle.

## Timing
- Latency: a word pushed at edge N is visible on out_valid/out_data after edge N, so it can be popped at edge N+1. There is no fall-through within the same cycle.
- Throughput: one push and one pop per cycle sustained when 0 < level < DEPTH.
- The producer must hold in_data stable while in_valid=1 and in_ready=0. in_valid must not drop before acceptance.
- out_data/out_valid remain stable while out_valid=1 and out_ready=0.

## Configuration
- Macro: LEAF_FIFO_STATS_EN.
- Defined:
  - push_cnt port exists. It increments on every accepted push and saturates at 16'hFFFF.
  - It is cleared only by rst_n.
- Undefined: push_cnt port and counter are absent. All other behaviour is identical.

## Structure
- Package leaf_fifo_pkg:
  - LEAF_DATA_W_DEF=8, LEAF_DEPTH_DEF=4, STATS_W=16
  - typedef leaf_word_t = logic [LEAF_DATA_W_DEF-1:0]
- One sub-module, leaf_fifo_ptr: a wrap-around pointer register with an advance enable and a synchronous clear. It is instantiated twice, for rd and wr.
- Storage is a plain register array in the top; no RAM macro.

## Test plan
- Reset, then idle 3 cycles → level=0, out_valid=0, in_ready=1, push_cnt=0.
- Push 0x11,0x22,0x33,0x44 back-to-back with out_ready=0 → level=4, in_ready=0. Fifth word 0x55 is held unaccepted. Then pop 4 → outputs 0x11..0x44 in order; 0x55 accepted the cycle after first pop.
- Continuous push and pop with out_ready=1 for 20 words 0x00..0x13 → level settles at 1, no bubbles after the first word, data order preserved across pointer wrap.
- Level=2 with flush=1 and in_valid=1 in the same cycle → next cycle level=0, out_valid=0, pushed word dropped, push_cnt unchanged.
- rst_n low for 1 cycle while level=3 → out_valid=0 and level=0 immediately. After release, a push of 0xA5 appears at the head with no stale data.
- With LEAF_FIFO_STATS_EN and push_cnt preset near saturation via 65540 pushes → push_cnt holds 16'hFFFF.
